// File: rtl/alarm_timekeeper_ctrl.sv
// Alarm clock controller: 24 h time-of-day counter, alarm compare, set-mode FSM,
// ring timeout and snooze re-arm. Every output comes straight from a flop.
module alarm_timekeeper_ctrl #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_snooze,
    input  logic       alarm_en,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic [2:0] set_state,
    output logic       ringing
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HR   = 3'd1,
        SET_MIN  = 3'd2,
        SET_AHR  = 3'd3,
        SET_AMIN = 3'd4
    } set_state_e;

    set_state_e state_q, state_d;
    logic [4:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic [4:0] alarm_hours_q, alarm_hours_d;
    logic [5:0] alarm_minutes_q, alarm_minutes_d;
    logic       ringing_q, ringing_d;
    logic       snooze_active_q, snooze_active_d;
    logic [4:0] snooze_hours_q, snooze_hours_d;
    logic [5:0] snooze_minutes_q, snooze_minutes_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;

    logic       time_runs;
    logic       advance;
    logic       inc_ok;
    logic [4:0] adv_h;
    logic [5:0] adv_m;
    logic [5:0] adv_s;
    logic       alarm_hit;
    logic       snooze_hit;
    logic [6:0] snz_sum;
    logic [6:0] snz_wrap;
    logic [4:0] tgt_h;
    logic [5:0] tgt_m;
    logic [8:0] ring_cnt_inc;
    logic       ring_timeout;

    // Time only stands still while the user is editing it.
    assign time_runs = (state_q == RUN) || (state_q == SET_AHR) || (state_q == SET_AMIN);
    assign advance   = tick && time_runs;
    assign inc_ok    = btn_inc && !btn_mode;

    always_comb begin
        adv_h = hours_q;
        adv_m = minutes_q;
        adv_s = seconds_q;
        if (seconds_q == 6'd59) begin
            adv_s = 6'd0;
            if (minutes_q == 6'd59) begin
                adv_m = 6'd0;
                adv_h = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
            end else begin
                adv_m = minutes_q + 6'd1;
            end
        end else begin
            adv_s = seconds_q + 6'd1;
        end
    end

    assign alarm_hit  = advance && (adv_s == 6'd0) &&
                        (adv_m == alarm_minutes_q) && (adv_h == alarm_hours_q);
    assign snooze_hit = advance && snooze_active_q && (adv_s == 6'd0) &&
                        (adv_m == snooze_minutes_q) && (adv_h == snooze_hours_q);

    // Snooze target is taken from the displayed hh:mm, wrapping past midnight.
    assign snz_sum  = {1'b0, minutes_q} + 7'(SNOOZE_MIN);
    assign snz_wrap = snz_sum - 7'd60;

    always_comb begin
        tgt_h = hours_q;
        tgt_m = snz_sum[5:0];
        if (snz_sum >= 7'd60) begin
            tgt_m = snz_wrap[5:0];
            tgt_h = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
        end
    end

    assign ring_cnt_inc = {1'b0, ring_cnt_q} + 9'd1;
    assign ring_timeout = (ring_cnt_inc == 9'(RING_TIMEOUT_S));

    always_comb begin
        state_d          = state_q;
        hours_d          = hours_q;
        minutes_d        = minutes_q;
        seconds_d        = seconds_q;
        alarm_hours_d    = alarm_hours_q;
        alarm_minutes_d  = alarm_minutes_q;
        ringing_d        = ringing_q;
        snooze_active_d  = snooze_active_q;
        snooze_hours_d   = snooze_hours_q;
        snooze_minutes_d = snooze_minutes_q;
        ring_cnt_d       = ring_cnt_q;

        if (btn_mode) begin
            case (state_q)
                RUN:      state_d = SET_HR;
                SET_HR:   state_d = SET_MIN;
                SET_MIN:  state_d = SET_AHR;
                SET_AHR:  state_d = SET_AMIN;
                default:  state_d = RUN;
            endcase
        end else begin
            case (state_q)
                RUN, SET_HR, SET_MIN, SET_AHR, SET_AMIN: state_d = state_q;
                default:                                 state_d = RUN;
            endcase
        end

        if (advance) begin
            hours_d   = adv_h;
            minutes_d = adv_m;
            seconds_d = adv_s;
        end

        if (inc_ok) begin
            case (state_q)
                SET_HR: begin
                    hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                end
                SET_MIN: begin
                    minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
                    seconds_d = 6'd0;
                end
                SET_AHR: begin
                    alarm_hours_d   = (alarm_hours_q == 5'd23) ? 5'd0 : alarm_hours_q + 5'd1;
                    snooze_active_d = 1'b0;
                end
                SET_AMIN: begin
                    alarm_minutes_d = (alarm_minutes_q == 6'd59) ? 6'd0 : alarm_minutes_q + 6'd1;
                    snooze_active_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (ringing_q) begin
            if (tick) begin
                ring_cnt_d = ring_cnt_inc[7:0];
                if (ring_timeout) begin
                    ringing_d  = 1'b0;
                    ring_cnt_d = 8'd0;
                end
            end
            // Snooze wins over a simultaneous auto-stop so the re-ring is armed.
            if (btn_snooze) begin
                ringing_d        = 1'b0;
                ring_cnt_d       = 8'd0;
                snooze_hours_d   = tgt_h;
                snooze_minutes_d = tgt_m;
                snooze_active_d  = !(inc_ok && (state_q == SET_AHR || state_q == SET_AMIN));
            end
        end else begin
            if (snooze_hit) begin
                ringing_d       = 1'b1;
                ring_cnt_d      = 8'd0;
                snooze_active_d = 1'b0;
            end
            if (alarm_hit) begin
                ringing_d  = 1'b1;
                ring_cnt_d = 8'd0;
            end
        end

        if (!alarm_en) begin
            ringing_d       = 1'b0;
            snooze_active_d = 1'b0;
            ring_cnt_d      = 8'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q          <= RUN;
            hours_q          <= 5'd0;
            minutes_q        <= 6'd0;
            seconds_q        <= 6'd0;
            alarm_hours_q    <= 5'd6;
            alarm_minutes_q  <= 6'd0;
            ringing_q        <= 1'b0;
            snooze_active_q  <= 1'b0;
            snooze_hours_q   <= 5'd0;
            snooze_minutes_q <= 6'd0;
            ring_cnt_q       <= 8'd0;
        end else begin
            state_q          <= state_d;
            hours_q          <= hours_d;
            minutes_q        <= minutes_d;
            seconds_q        <= seconds_d;
            alarm_hours_q    <= alarm_hours_d;
            alarm_minutes_q  <= alarm_minutes_d;
            ringing_q        <= ringing_d;
            snooze_active_q  <= snooze_active_d;
            snooze_hours_q   <= snooze_hours_d;
            snooze_minutes_q <= snooze_minutes_d;
            ring_cnt_q       <= ring_cnt_d;
        end
    end

    assign hours         = hours_q;
    assign minutes       = minutes_q;
    assign seconds       = seconds_q;
    assign alarm_hours   = alarm_hours_q;
    assign alarm_minutes = alarm_minutes_q;
    assign set_state     = state_q;
    assign ringing       = ringing_q;

endmodule

// File: tb/tb_alarm_timekeeper_ctrl.sv
// Bench for alarm_timekeeper_ctrl: a seconds-of-day reference model feeds an expected
// queue drained every cycle, plus directed checks of the headline time/ring values.
module tb_alarm_timekeeper_ctrl;
    localparam int SNOOZE_MIN = 5;
    localparam int RING_T     = 60;

    logic       clock = 1'b0;
    logic       clear = 1'b0, tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
    logic       btn_snooze = 1'b0, alarm_en = 1'b0;
    logic [4:0] hours, alarm_hours;
    logic [5:0] minutes, seconds, alarm_minutes;
    logic [2:0] set_state;
    logic       ringing;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    int m_state, m_tod, m_ah, m_am, m_rcnt, m_tgt;
    bit m_ring, m_snz;
    bit en_lvl = 1'b1;

    alarm_timekeeper_ctrl #(.SNOOZE_MIN(SNOOZE_MIN), .RING_TIMEOUT_S(RING_T)) dut (
        .clock(clock), .clear(clear), .tick(tick), .btn_mode(btn_mode),
        .btn_inc(btn_inc), .btn_snooze(btn_snooze), .alarm_en(alarm_en),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .set_state(set_state), .ringing(ringing)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, observed time %0t, required under 1000000", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pack_model();
        return {5'(m_tod / 3600), 6'((m_tod / 60) % 60), 6'(m_tod % 60),
                5'(m_ah), 6'(m_am), 3'(m_state), m_ring};
    endfunction

    task automatic model_step(input bit t, input bit md, input bit in, input bit sn,
                              input bit en, input bit cl);
        int old_tod, new_tod, h, m;
        bit adv, inc_eff, n_ring, n_snz;
        if (cl) begin
            m_state = 0; m_tod = 0; m_ah = 6; m_am = 0;
            m_ring = 0; m_snz = 0; m_rcnt = 0; m_tgt = 0;
            return;
        end
        old_tod = m_tod;
        h = old_tod / 3600;
        m = (old_tod / 60) % 60;
        adv = t && (m_state == 0 || m_state == 3 || m_state == 4);
        inc_eff = in && !md;
        new_tod = adv ? (old_tod + 1) % 86400 : old_tod;
        n_ring = m_ring;
        n_snz = m_snz;
        if (m_ring) begin
            if (t) begin
                m_rcnt++;
                if (m_rcnt == RING_T) begin n_ring = 0; m_rcnt = 0; end
            end
            if (sn) begin
                n_ring = 0; m_rcnt = 0; n_snz = 1;
                m_tgt = (h * 60 + m + SNOOZE_MIN) % 1440;
            end
        end else if (adv && en) begin
            if (m_snz && new_tod == m_tgt * 60) begin n_ring = 1; n_snz = 0; m_rcnt = 0; end
            if (new_tod == m_ah * 3600 + m_am * 60) begin n_ring = 1; m_rcnt = 0; end
        end
        if (inc_eff) begin
            case (m_state)
                1: new_tod = ((h + 1) % 24) * 3600 + m * 60 + old_tod % 60;
                2: new_tod = h * 3600 + ((m + 1) % 60) * 60;
                3: begin m_ah = (m_ah + 1) % 24; n_snz = 0; end
                4: begin m_am = (m_am + 1) % 60; n_snz = 0; end
                default: ;
            endcase
        end
        if (!en) begin n_ring = 0; n_snz = 0; m_rcnt = 0; end
        m_tod = new_tod;
        m_ring = n_ring;
        m_snz = n_snz;
        if (md) m_state = (m_state == 4) ? 0 : m_state + 1;
    endtask

    // Driver: one clock cycle of stimulus, expected outputs queued for the monitor.
    task automatic step(input bit t, input bit md, input bit in, input bit sn, input bit cl);
        tick = t; btn_mode = md; btn_inc = in; btn_snooze = sn; clear = cl; alarm_en = en_lvl;
        model_step(t, md, in, sn, en_lvl, cl);
        exp_q.push_back(pack_model());
        @(posedge clock);
        #2;
    endtask

    always @(posedge clock) begin : monitor
        logic [31:0] e, g;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {hours, minutes, seconds, alarm_hours, alarm_minutes, set_state, ringing};
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL scoreboard t=%0t observed %h required %h", $time, g, e);
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) step(1, 0, 0, 0, 0);
    endtask

    task automatic goto_time(input int h, input int m, input int ah, input int am);
        int k;
        step(0, 1, 0, 0, 0);
        k = (h - m_tod / 3600 + 24) % 24;
        repeat (k) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        k = (m - (m_tod / 60) % 60 + 60) % 60;
        if (k == 0) k = 60;
        repeat (k) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        k = (ah - m_ah + 24) % 24;
        repeat (k) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        k = (am - m_am + 60) % 60;
        repeat (k) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
    endtask

    task automatic test_reset();
        logic [31:0] g, r;
        en_lvl = 1;
        step(0, 0, 0, 0, 1);
        r = {5'd0, 6'd0, 6'd0, 5'd6, 6'd0, 3'd0, 1'b0};
        g = {hours, minutes, seconds, alarm_hours, alarm_minutes, set_state, ringing};
        n_vec++;
        if (g !== r) begin n_err++; $display("FAIL reset_state observed %h required %h", g, r); end
    endtask

    task automatic test_rollover();
        step(0, 0, 0, 0, 1);
        goto_time(23, 59, 6, 0);
        tick_n(59);
        n_vec++;
        if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd59}) begin
            n_err++; $display("FAIL pre_rollover observed %0d:%0d:%0d required 23:59:59", hours, minutes, seconds);
        end
        tick_n(1);
        n_vec++;
        if ({hours, minutes, seconds, ringing} !== 18'd0) begin
            n_err++; $display("FAIL rollover observed %0d:%0d:%0d ring=%b required 0:0:0 ring=0", hours, minutes, seconds, ringing);
        end
    endtask

    task automatic test_alarm_ring();
        step(0, 0, 0, 0, 1);
        goto_time(5, 59, 6, 0);
        tick_n(59);
        step(1, 0, 0, 1, 0);
        n_vec++;
        if ({hours, minutes, seconds, ringing} !== {5'd6, 6'd0, 6'd0, 1'b1}) begin
            n_err++; $display("FAIL alarm_rise observed %0d:%0d:%0d ring=%b required 6:0:0 ring=1", hours, minutes, seconds, ringing);
        end
        tick_n(59);
        n_vec++;
        if (ringing !== 1'b1) begin n_err++; $display("FAIL ring_hold observed %b required 1", ringing); end
        tick_n(1);
        n_vec++;
        if (ringing !== 1'b0) begin n_err++; $display("FAIL auto_stop observed %b required 0", ringing); end
        tick_n(300);
        n_vec++;
        if (ringing !== 1'b0) begin n_err++; $display("FAIL no_snooze_after_stop observed %b required 0", ringing); end
    endtask

    task automatic test_snooze();
        step(0, 0, 0, 0, 1);
        goto_time(5, 59, 6, 0);
        tick_n(60);
        step(0, 0, 0, 1, 0);
        n_vec++;
        if (ringing !== 1'b0) begin n_err++; $display("FAIL snooze_stop observed %b required 0", ringing); end
        tick_n(299);
        n_vec++;
        if (ringing !== 1'b0) begin n_err++; $display("FAIL snooze_early observed %b required 0", ringing); end
        tick_n(1);
        n_vec++;
        if ({hours, minutes, seconds, ringing} !== {5'd6, 6'd5, 6'd0, 1'b1}) begin
            n_err++; $display("FAIL snooze_rering observed %0d:%0d:%0d ring=%b required 6:5:0 ring=1", hours, minutes, seconds, ringing);
        end
    endtask

    task automatic test_snooze_wrap();
        step(0, 0, 0, 0, 1);
        goto_time(23, 57, 23, 58);
        tick_n(60);
        step(0, 0, 0, 1, 0);
        tick_n(300);
        n_vec++;
        if ({hours, minutes, seconds, ringing} !== {5'd0, 6'd3, 6'd0, 1'b1}) begin
            n_err++; $display("FAIL snooze_wrap observed %0d:%0d:%0d ring=%b required 0:3:0 ring=1", hours, minutes, seconds, ringing);
        end
    endtask

    task automatic test_stop_and_snooze();
        step(0, 0, 0, 0, 1);
        goto_time(5, 59, 6, 0);
        tick_n(60);
        tick_n(59);
        step(1, 0, 0, 1, 0);
        n_vec++;
        if (ringing !== 1'b0) begin n_err++; $display("FAIL stop_snooze_edge observed %b required 0", ringing); end
        tick_n(240);
        n_vec++;
        if ({hours, minutes, ringing} !== {5'd6, 6'd5, 1'b1}) begin
            n_err++; $display("FAIL stop_snooze_rering observed %0d:%0d ring=%b required 6:5 ring=1", hours, minutes, ringing);
        end
    endtask

    task automatic test_set_sequence();
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        n_vec++;
        if (set_state !== 3'd1) begin n_err++; $display("FAIL set_hr_state observed %0d required 1", set_state); end
        repeat (3) step(0, 0, 1, 0, 0);
        tick_n(5);
        n_vec++;
        if ({hours, minutes, seconds} !== {5'd3, 6'd0, 6'd0}) begin
            n_err++; $display("FAIL set_hr_frozen observed %0d:%0d:%0d required 3:0:0", hours, minutes, seconds);
        end
        step(0, 1, 1, 0, 0);
        n_vec++;
        if ({set_state, minutes} !== {3'd2, 6'd0}) begin
            n_err++; $display("FAIL mode_beats_inc observed state=%0d min=%0d required state=2 min=0", set_state, minutes);
        end
        repeat (3) step(0, 1, 0, 0, 0);
        n_vec++;
        if (set_state !== 3'd0) begin n_err++; $display("FAIL back_to_run observed %0d required 0", set_state); end
    endtask

    task automatic test_en_drop();
        step(0, 0, 0, 0, 1);
        goto_time(5, 59, 6, 0);
        tick_n(60);
        step(0, 0, 0, 1, 0);
        en_lvl = 0;
        step(0, 0, 0, 0, 0);
        en_lvl = 1;
        tick_n(300);
        n_vec++;
        if ({hours, minutes, ringing} !== {5'd6, 6'd5, 1'b0}) begin
            n_err++; $display("FAIL en_drop_kills_snooze observed %0d:%0d ring=%b required 6:5 ring=0", hours, minutes, ringing);
        end
    endtask

    task automatic test_clear_mid();
        logic [31:0] g, r;
        r = {5'd0, 6'd0, 6'd0, 5'd6, 6'd0, 3'd0, 1'b0};
        step(0, 0, 0, 0, 1);
        goto_time(5, 59, 6, 0);
        tick_n(60);
        repeat (4) step(0, 1, 0, 0, 0);
        n_vec++;
        if ({set_state, ringing} !== {3'd4, 1'b1}) begin
            n_err++; $display("FAIL ring_in_set_amin observed state=%0d ring=%b required state=4 ring=1", set_state, ringing);
        end
        step(0, 0, 0, 0, 1);
        g = {hours, minutes, seconds, alarm_hours, alarm_minutes, set_state, ringing};
        n_vec++;
        if (g !== r) begin n_err++; $display("FAIL clear_mid_ring observed %h required %h", g, r); end
        goto_time(5, 59, 6, 0);
        tick_n(60);
        step(0, 0, 0, 1, 0);
        repeat (4) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        goto_time(6, 4, 6, 0);
        tick_n(60);
        n_vec++;
        if ({hours, minutes, ringing} !== {5'd6, 6'd5, 1'b0}) begin
            n_err++; $display("FAIL clear_drops_snooze observed %0d:%0d ring=%b required 6:5 ring=0", hours, minutes, ringing);
        end
    endtask

    task automatic test_random();
        bit t, md, in, sn, cl;
        step(0, 0, 0, 0, 1);
        goto_time(5, 58, 6, 0);
        for (int i = 0; i < 500; i++) begin
            t  = ($urandom_range(0, 3) != 0);
            md = ($urandom_range(0, 23) == 0);
            in = ($urandom_range(0, 3) == 0);
            sn = ($urandom_range(0, 9) == 0);
            cl = ($urandom_range(0, 299) == 0);
            en_lvl = ($urandom_range(0, 39) != 0);
            step(t, md, in, sn, cl);
        end
        en_lvl = 1;
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_alarm_ring();
        test_snooze();
        test_snooze_wrap();
        test_stop_and_snooze();
        test_set_sequence();
        test_en_drop();
        test_clear_mid();
        test_random();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL queue_drain observed %0d entries required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
